pipelined_instruction_decoder: RTL and testbench
================================================

Name: pipelined_instruction_decoder

Overview:
- Registered, handshaked successor to the single-cycle instruction decoder, for the pipelined CPU's ID stage.
- Decodes one 32-bit MIPS instruction per cycle into the existing control-line set, plus register fields, immediate and PC.
- Registers all outputs behind a valid/ready handshake.
- Detects load-use hazards and inserts a parametrised number of NOP bubbles.
- Supports pipeline flush and an optional extended opcode set.

Parameters:
- PC_W, 32, width of pc_in/pc_out.
- LOAD_USE_BUBBLES, 1, NOP bubbles inserted after a load on a load-use hazard (1..7).
- ENABLE_EXT_OPS, 1, when 1 also decodes sub, subu, and, or, xor, j, xori; when 0 these are illegal.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  upstream instruction valid
- if_ready  out  1  decoder accepts instruction this cycle
- instruction  in  32  instruction word
- pc_in  in  PC_W  PC+4 of instruction
- flush  in  1  discard held/incoming instruction (branch/jump taken)
- id_valid  out  1  decoded bundle valid
- id_ready  in  1  downstream accepts bundle
- id_bubble  out  1  bundle is a hazard NOP
- illegal_op  out  1  bundle came from an undecodable instruction
- RegDst  out  2  0=RT, 1=RD, 2=RA
- ExtendMethod  out  1  0=sign-extend, 1=zero-extend
- RegWr, Branch, Jump, MemWr, MemToReg, DMAddrsrc, JumpReg, InvZero  out  1 each  as in the existing control set
- ALUsrc  out  2  0=immediate, 1=PC, 2=Db
- ALUcntrl  out  3  ADD=0 SUB=1 XOR=2 SLT=3 AND=4 OR=7
- rs, rt, rd  out  5 each  register fields
- imm  out  16  instruction[15:0]
- jtarget  out  26  instruction[25:0]
- pc_out  out  PC_W  registered pc_in

Behaviour:
- Reset (sync, highest priority):
  - all outputs 0; id_valid=0; id_bubble=0.
  - FSM -> RUN; bubble counter -> 0.
- Latency: an instruction accepted at edge N appears on the outputs after edge N, i.e. 1 cycle.
- Handshake:
  - Accept when if_valid && if_ready.
  - Outputs are stable while id_valid && !id_ready.
  - Combinational term `can_load` = !id_valid || id_ready.
- Decode table (opcode 0 uses funct):
  - addu, add: RD, RegWr, ALUsrc=Db, ADD.
  - sub, subu: SUB. and: AND. or: OR. xor: XOR.
  - slt: RegWr=1, SLT.
  - jr: JumpReg=1, RegWr=0.
  - addi, addiu: RT, RegWr, imm, ADD, ExtendMethod=0.
  - xori: RT, RegWr, imm, XOR, ExtendMethod=1.
  - beq: Branch, SUB, InvZero=0. bne: Branch, SUB, InvZero=1.
  - lw: RT, RegWr, MemToReg, ADD, imm. sw: MemWr, ADD, imm.
  - j: Jump. jal: RA, RegWr, Jump, ALUsrc=PC.
  - Anything else: all controls 0, illegal_op=1, id_valid=1.
- Hazard check (combinational):
  - Fires when the output register holds a valid non-bubble lw with rt!=0, and the incoming instruction reads that register.
  - Incoming reads rs: all ops except j, jal.
  - Incoming reads rt: R-type except jr; beq, bne, sw.
- FSM RUN:
  - if_ready = can_load && !hazard.
  - On hazard && id_ready: load a NOP (id_valid=1, id_bubble=1, all controls 0); counter = LOAD_USE_BUBBLES-1; go to STALL if counter>0, else stay in RUN.
  - Otherwise, on accept: load the decoded bundle.
  - If the output is drained with no accept: id_valid -> 0.
- FSM STALL:
  - if_ready=0.
  - Each cycle the NOP is taken (id_ready=1): reload NOP and decrement the counter.
  - At 0 -> RUN.
  - The hazard re-evaluates against the NOP (not a lw), so the dependent instruction is accepted next.
- flush (below reset, above everything else):
  - Output register -> id_valid=0, controls 0.
  - FSM -> RUN; counter -> 0.
  - if_ready=1 that cycle; any presented instruction is consumed and discarded.
- rs/rt/rd/imm/jtarget/pc_out: captured with the bundle; zeroed for bubbles and flush.
- Downstream stall: a hazard persists while the lw is held; no bubble is inserted until the lw is taken.
- Reset or flush mid-STALL aborts the remaining bubbles.

Decomposition:
- Shared package `cpu_defs`: opcode/funct constants, RegDst/ALUsrc/ALUcntrl encodings, a control-bundle struct, and the NOP bundle constant.
- One sub-module `decode_lut`: purely combinational instruction -> control bundle + illegal flag, parametrised by ENABLE_EXT_OPS.
- The top level holds the pipeline register, hazard logic and FSM.

Test Plan:
- Reset then addi $7,$2,15 (0x2047000F) with id_ready=1 -> next cycle id_valid=1, RegDst=0, RegWr=1, ALUsrc=0, ALUcntrl=0, rt=7, imm=0x000F.
- lw $8,0($2) then add $9,$8,$3, LOAD_USE_BUBBLES=2 -> lw, then 2 cycles id_bubble=1 with if_ready=0, then add with rs=8, rd=9; add accepted exactly 3 cycles after lw accepted.
- lw $0,0($2) then add $9,$0,$3 -> no bubble; add follows in the next cycle.
- id_ready=0 for 3 cycles holding bne (0x14470003) -> outputs stable with InvZero=1, Branch=1, ALUcntrl=1, if_ready=0; release -> next instruction accepted.
- flush asserted during a STALL bubble -> next cycle id_valid=0 and FSM in RUN; the instruction presented during flush never appears on the output.
- ENABLE_EXT_OPS=0, sub (funct 0x22) -> illegal_op=1, all controls 0; ENABLE_EXT_OPS=1 -> ALUcntrl=1, RegWr=1, RegDst=1.

Source files
------------

// File: rtl/pipelined_instruction_decoder_pkg.sv
// ============================================================================
// Module   : cpu_defs (package)
// Purpose  : Shared definitions for the pipelined ID stage: MIPS opcode and
//            funct constants, control-line encodings, the control bundle and
//            the registered decode bundle, plus register-read helpers used by
//            the load-use hazard check.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_defs;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    REGDST_RT = 2'd0,
    REGDST_RD = 2'd1,
    REGDST_RA = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    ALUSRC_IMM = 2'd0,
    ALUSRC_PC  = 2'd1,
    ALUSRC_DB  = 2'd2
  } alu_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd7
  } alu_ctrl_e;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  typedef struct packed {
    reg_dst_e  reg_dst;
    logic      extend_method;
    logic      reg_wr;
    logic      branch;
    logic      jump;
    logic      mem_wr;
    logic      mem_to_reg;
    logic      dm_addr_src;
    logic      jump_reg;
    logic      inv_zero;
    alu_src_e  alu_src;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  // All control lines inactive; used for bubbles, illegal ops and flush.
  localparam ctrl_t CTRL_NOP = '{
    reg_dst:       REGDST_RT,
    extend_method: 1'b0,
    reg_wr:        1'b0,
    branch:        1'b0,
    jump:          1'b0,
    mem_wr:        1'b0,
    mem_to_reg:    1'b0,
    dm_addr_src:   1'b0,
    jump_reg:      1'b0,
    inv_zero:      1'b0,
    alu_src:       ALUSRC_IMM,
    alu_ctrl:      ALU_ADD
  };

  typedef struct packed {
    logic        bubble;
    logic        illegal;
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] jtarget;
  } bundle_t;

  // Every instruction sources rs except the absolute jumps.
  function automatic logic reads_rs(input logic [31:0] instr);
    return !((instr[31:26] == OP_J) || (instr[31:26] == OP_JAL));
  endfunction

  // rt is a source for R-type (jr only uses rs), branches and stores.
  function automatic logic reads_rt(input logic [31:0] instr);
    return ((instr[31:26] == OP_RTYPE) && (instr[5:0] != FN_JR)) ||
           (instr[31:26] == OP_BEQ) || (instr[31:26] == OP_BNE) ||
           (instr[31:26] == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_instruction_decoder_decode_lut.sv
// ============================================================================
// Module   : decode_lut
// Purpose  : Purely combinational opcode/funct -> control bundle lookup.
//            Unknown encodings (and the extended set when ENABLE_EXT_OPS=0)
//            produce an all-zero bundle with illegal=1.
// Ports    : opcode  in  6   instruction[31:26]
//            funct   in  6   instruction[5:0]
//            ctrl    out     decoded control bundle
//            illegal out 1   encoding not recognised
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_lut
  import cpu_defs::*;
#(
  parameter int ENABLE_EXT_OPS = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  localparam logic EXT = (ENABLE_EXT_OPS != 0);

  logic legal;

  always_comb begin
    ctrl  = CTRL_NOP;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        // Register-register ALU ops share destination and operand source.
        ctrl.reg_dst = REGDST_RD;
        ctrl.reg_wr  = 1'b1;
        ctrl.alu_src = ALUSRC_DB;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: begin ctrl.alu_ctrl = ALU_SUB; legal = EXT; end
          FN_AND:          begin ctrl.alu_ctrl = ALU_AND; legal = EXT; end
          FN_OR:           begin ctrl.alu_ctrl = ALU_OR;  legal = EXT; end
          FN_XOR:          begin ctrl.alu_ctrl = ALU_XOR; legal = EXT; end
          FN_SLT:          ctrl.alu_ctrl = ALU_SLT;
          FN_JR: begin
            ctrl          = CTRL_NOP;
            ctrl.jump_reg = 1'b1;
          end
          default:         legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.reg_wr = 1'b1;
      end
      OP_XORI: begin
        ctrl.reg_wr        = 1'b1;
        ctrl.extend_method = 1'b1;
        ctrl.alu_ctrl      = ALU_XOR;
        legal              = EXT;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_src  = ALUSRC_DB;
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.inv_zero = (opcode == OP_BNE);
      end
      OP_LW: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_wr = 1'b1;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
        legal     = EXT;
      end
      OP_JAL: begin
        ctrl.reg_dst = REGDST_RA;
        ctrl.reg_wr  = 1'b1;
        ctrl.jump    = 1'b1;
        ctrl.alu_src = ALUSRC_PC;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl = CTRL_NOP;
    end
    illegal = !legal;
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_instruction_decoder.sv
// ============================================================================
// Module   : pipelined_instruction_decoder
// Purpose  : Registered ID stage. Decodes one MIPS instruction per cycle into
//            a control bundle held behind a valid/ready handshake, inserts
//            LOAD_USE_BUBBLES NOPs on a load-use hazard, and supports flush.
// Ports    : clk, reset                 clock, sync active-high reset
//            if_valid/if_ready          upstream handshake
//            instruction, pc_in         incoming word and its PC+4
//            flush                      drop held/incoming instruction
//            id_valid/id_ready          downstream handshake
//            id_bubble, illegal_op      bundle qualifiers
//            RegDst..ALUcntrl           control lines
//            rs, rt, rd, imm, jtarget   instruction fields
//            pc_out                     registered pc_in
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_instruction_decoder
  import cpu_defs::*;
#(
  parameter int PC_W             = 32,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int ENABLE_EXT_OPS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic            id_bubble,
  output logic            illegal_op,
  output logic [1:0]      RegDst,
  output logic            ExtendMethod,
  output logic            RegWr,
  output logic            Branch,
  output logic            Jump,
  output logic            MemWr,
  output logic            MemToReg,
  output logic            DMAddrsrc,
  output logic            JumpReg,
  output logic            InvZero,
  output logic [1:0]      ALUsrc,
  output logic [2:0]      ALUcntrl,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [15:0]     imm,
  output logic [25:0]     jtarget,
  output logic [PC_W-1:0] pc_out
);

  // Bubbles still owed after the first NOP is loaded.
  localparam logic [2:0] BUB_RELOAD = 3'(LOAD_USE_BUBBLES - 1);

  ctrl_t           dec_ctrl;
  logic            dec_illegal;
  bundle_t         dec_bundle;
  bundle_t         nop_bundle;

  logic            id_valid_q, id_valid_d;
  bundle_t         bundle_q,   bundle_d;
  logic [PC_W-1:0] pc_q,       pc_d;
  state_e          state_q,    state_d;
  logic [2:0]      cnt_q,      cnt_d;

  logic            can_load;
  logic            hazard;

  decode_lut #(
    .ENABLE_EXT_OPS(ENABLE_EXT_OPS)
  ) u_decode_lut (
    .opcode (instruction[31:26]),
    .funct  (instruction[5:0]),
    .ctrl   (dec_ctrl),
    .illegal(dec_illegal)
  );

  always_comb begin
    dec_bundle         = '0;
    dec_bundle.illegal = dec_illegal;
    dec_bundle.ctrl    = dec_ctrl;
    dec_bundle.rs      = instruction[25:21];
    dec_bundle.rt      = instruction[20:16];
    dec_bundle.rd      = instruction[15:11];
    dec_bundle.imm     = instruction[15:0];
    dec_bundle.jtarget = instruction[25:0];

    nop_bundle         = '0;
    nop_bundle.bubble  = 1'b1;
    nop_bundle.ctrl    = CTRL_NOP;
  end

  assign can_load = !id_valid_q || id_ready;

  // A held, real lw (mem_to_reg only comes from lw) whose target is read by
  // the incoming instruction. A NOP in the register never triggers, which is
  // what lets the dependent instruction through once the bubbles are done.
  assign hazard = if_valid && id_valid_q && !bundle_q.bubble &&
                  bundle_q.ctrl.mem_to_reg && (bundle_q.rt != 5'd0) &&
                  ((reads_rs(instruction) && (instruction[25:21] == bundle_q.rt)) ||
                   (reads_rt(instruction) && (instruction[20:16] == bundle_q.rt)));

  always_comb begin
    id_valid_d = id_valid_q;
    bundle_d   = bundle_q;
    pc_d       = pc_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if_ready   = 1'b0;

    if (flush) begin
      // Swallow whatever is presented and clear the stage.
      if_ready      = 1'b1;
      id_valid_d    = 1'b0;
      bundle_d      = '0;
      bundle_d.ctrl = CTRL_NOP;
      pc_d          = '0;
      state_d       = ST_RUN;
      cnt_d         = 3'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if_ready = can_load && !hazard;
          if (hazard && id_ready) begin
            id_valid_d = 1'b1;
            bundle_d   = nop_bundle;
            pc_d       = '0;
            cnt_d      = BUB_RELOAD;
            state_d    = (BUB_RELOAD != 3'd0) ? ST_STALL : ST_RUN;
          end else if (if_valid && if_ready) begin
            id_valid_d = 1'b1;
            bundle_d   = dec_bundle;
            pc_d       = pc_in;
          end else if (id_ready) begin
            id_valid_d = 1'b0;
          end
        end
        ST_STALL: begin
          if (id_ready) begin
            id_valid_d = 1'b1;
            bundle_d   = nop_bundle;
            pc_d       = '0;
            cnt_d      = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              state_d = ST_RUN;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      bundle_q   <= '0;
      pc_q       <= '0;
      state_q    <= ST_RUN;
      cnt_q      <= 3'd0;
    end else begin
      id_valid_q <= id_valid_d;
      bundle_q   <= bundle_d;
      pc_q       <= pc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_bubble    = bundle_q.bubble;
  assign illegal_op   = bundle_q.illegal;
  assign RegDst       = bundle_q.ctrl.reg_dst;
  assign ExtendMethod = bundle_q.ctrl.extend_method;
  assign RegWr        = bundle_q.ctrl.reg_wr;
  assign Branch       = bundle_q.ctrl.branch;
  assign Jump         = bundle_q.ctrl.jump;
  assign MemWr        = bundle_q.ctrl.mem_wr;
  assign MemToReg     = bundle_q.ctrl.mem_to_reg;
  assign DMAddrsrc    = bundle_q.ctrl.dm_addr_src;
  assign JumpReg      = bundle_q.ctrl.jump_reg;
  assign InvZero      = bundle_q.ctrl.inv_zero;
  assign ALUsrc       = bundle_q.ctrl.alu_src;
  assign ALUcntrl     = bundle_q.ctrl.alu_ctrl;
  assign rs           = bundle_q.rs;
  assign rt           = bundle_q.rt;
  assign rd           = bundle_q.rd;
  assign imm          = bundle_q.imm;
  assign jtarget      = bundle_q.jtarget;
  assign pc_out       = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_instruction_decoder.sv
// ============================================================================
// Module   : tb_pipelined_instruction_decoder
// Purpose  : Scoreboard bench. Two decoders share all inputs: the main one
//            (extended ops on, 2 load-use bubbles) and one with extended ops
//            off, whose control lines are compared on every bundle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipelined_instruction_decoder;

  logic        clk = 1'b0;
  logic        reset, if_valid, flush, id_ready;
  logic [31:0] instruction, pc_in;

  logic        if_ready, id_valid, id_bubble, illegal_op;
  logic [1:0]  RegDst, ALUsrc;
  logic        ExtendMethod, RegWr, Branch, Jump, MemWr, MemToReg, DMAddrsrc, JumpReg, InvZero;
  logic [2:0]  ALUcntrl;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] jtarget;
  logic [31:0] pc_out;

  logic        x_if_ready, x_id_valid, x_id_bubble, x_illegal_op;
  logic [1:0]  x_RegDst, x_ALUsrc;
  logic        x_ExtendMethod, x_RegWr, x_Branch, x_Jump, x_MemWr, x_MemToReg, x_DMAddrsrc, x_JumpReg, x_InvZero;
  logic [2:0]  x_ALUcntrl;
  logic [4:0]  x_rs, x_rt, x_rd;
  logic [15:0] x_imm;
  logic [25:0] x_jtarget;
  logic [31:0] x_pc_out;

  pipelined_instruction_decoder #(.PC_W(32), .LOAD_USE_BUBBLES(2), .ENABLE_EXT_OPS(1)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .instruction(instruction), .pc_in(pc_in), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_bubble(id_bubble), .illegal_op(illegal_op),
    .RegDst(RegDst), .ExtendMethod(ExtendMethod), .RegWr(RegWr), .Branch(Branch), .Jump(Jump),
    .MemWr(MemWr), .MemToReg(MemToReg), .DMAddrsrc(DMAddrsrc), .JumpReg(JumpReg), .InvZero(InvZero),
    .ALUsrc(ALUsrc), .ALUcntrl(ALUcntrl), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .jtarget(jtarget), .pc_out(pc_out)
  );

  pipelined_instruction_decoder #(.PC_W(32), .LOAD_USE_BUBBLES(2), .ENABLE_EXT_OPS(0)) dut_x (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(x_if_ready),
    .instruction(instruction), .pc_in(pc_in), .flush(flush),
    .id_valid(x_id_valid), .id_ready(id_ready), .id_bubble(x_id_bubble), .illegal_op(x_illegal_op),
    .RegDst(x_RegDst), .ExtendMethod(x_ExtendMethod), .RegWr(x_RegWr), .Branch(x_Branch), .Jump(x_Jump),
    .MemWr(x_MemWr), .MemToReg(x_MemToReg), .DMAddrsrc(x_DMAddrsrc), .JumpReg(x_JumpReg), .InvZero(x_InvZero),
    .ALUsrc(x_ALUsrc), .ALUcntrl(x_ALUcntrl), .rs(x_rs), .rt(x_rt), .rd(x_rd), .imm(x_imm),
    .jtarget(x_jtarget), .pc_out(x_pc_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Control vector layout: RegDst, ExtendMethod, RegWr, Branch, Jump, MemWr,
  // MemToReg, DMAddrsrc, JumpReg, InvZero, ALUsrc, ALUcntrl (16 bits).
  function automatic logic [15:0] c(input logic [1:0] rdst, input logic e, rw, br, jp, mw, m2r, jrg, inv,
                                    input logic [1:0] src, input logic [2:0] alu);
    return {rdst, e, rw, br, jp, mw, m2r, 1'b0, jrg, inv, src, alu};
  endfunction

  // Reference decode: {illegal, ctrl}.
  function automatic logic [16:0] model(input logic [31:0] ins, input logic ext);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [16:0] r;
    op = ins[31:26];
    fn = ins[5:0];
    r  = {1'b1, 16'h0};
    case (op)
      6'h00: case (fn)
        6'h20, 6'h21: r = {1'b0, c(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0)};
        6'h22, 6'h23: if (ext) r = {1'b0, c(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd1)};
        6'h24: if (ext) r = {1'b0, c(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd4)};
        6'h25: if (ext) r = {1'b0, c(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd7)};
        6'h26: if (ext) r = {1'b0, c(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd2)};
        6'h2A: r = {1'b0, c(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd3)};
        6'h08: r = {1'b0, c(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0)};
        default: r = {1'b1, 16'h0};
      endcase
      6'h08, 6'h09: r = {1'b0, c(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0)};
      6'h0E: if (ext) r = {1'b0, c(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2)};
      6'h04: r = {1'b0, c(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd1)};
      6'h05: r = {1'b0, c(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd1)};
      6'h23: r = {1'b0, c(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0)};
      6'h2B: r = {1'b0, c(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0)};
      6'h02: if (ext) r = {1'b0, c(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0)};
      6'h03: r = {1'b0, c(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0)};
      default: r = {1'b1, 16'h0};
    endcase
    return r;
  endfunction

  // Bundle vector: bubble, illegal, ctrl(16), rs, rt, rd, imm, jtarget, pc (107 bits).
  typedef struct packed {
    logic [106:0] m;
    logic [16:0]  x;
  } exp_t;

  exp_t sbq[$];

  task automatic push_instr(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [16:0] mm;
    mm  = model(ins, 1'b1);
    e.m = {1'b0, mm, ins[25:21], ins[20:16], ins[15:11], ins[15:0], ins[25:0], pc};
    e.x = model(ins, 1'b0);
    sbq.push_back(e);
  endtask

  task automatic push_bubbles(input int n);
    exp_t e;
    e.m = {1'b1, 106'h0};
    e.x = 17'h0;
    for (int i = 0; i < n; i++) sbq.push_back(e);
  endtask

  wire [106:0] got_m = {id_bubble, illegal_op, RegDst, ExtendMethod, RegWr, Branch, Jump, MemWr,
                        MemToReg, DMAddrsrc, JumpReg, InvZero, ALUsrc, ALUcntrl,
                        rs, rt, rd, imm, jtarget, pc_out};
  wire [16:0]  got_x = {x_illegal_op, x_RegDst, x_ExtendMethod, x_RegWr, x_Branch, x_Jump, x_MemWr,
                        x_MemToReg, x_DMAddrsrc, x_JumpReg, x_InvZero, x_ALUsrc, x_ALUcntrl};

  // Scoreboard: every bundle taken downstream must be the next expected one.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && id_valid && id_ready) begin
      if (sbq.size() == 0) begin
        check_eq("unexpected_valid", {127'h0, id_valid}, 128'h0);
      end else begin
        e = sbq.pop_front();
        check_eq("bundle", {21'h0, got_m}, {21'h0, e.m});
        check_eq("bundle_ext0", {111'h0, got_x}, {111'h0, e.x});
      end
    end
  end

  logic [31:0] pc_next = 32'h0000_1004;

  // Present an instruction until accepted; returns the cycle of acceptance.
  // Returns just after the accepting edge so calls can run back-to-back.
  task automatic send(input logic [31:0] ins, output int acc);
    int   waited;
    logic done;
    waited      = 0;
    done        = 1'b0;
    acc         = -1;
    instruction = ins;
    pc_in       = pc_next;
    if_valid    = 1'b1;
    while (!done && waited < 20) begin
      @(negedge clk);
      if (if_ready) begin
        acc  = cyc;
        done = 1'b1;
        push_instr(ins, pc_next);
      end
      @(posedge clk); #1;
      waited++;
    end
    if_valid = 1'b0;
    check_eq("accept", {127'h0, done}, 128'h1);
    pc_next = pc_next + 32'd4;
  endtask

  localparam logic [31:0] I_ADDI  = 32'h2047000F;
  localparam logic [31:0] I_LW8   = 32'h8C480000;
  localparam logic [31:0] I_ADD8  = 32'h01034820;
  localparam logic [31:0] I_LW0   = 32'h8C400000;
  localparam logic [31:0] I_ADD0  = 32'h00034820;
  localparam logic [31:0] I_BNE   = 32'h14470003;
  localparam logic [31:0] I_FLUSH = 32'h20540001;

  logic [31:0] mix [14] = '{32'h00225022, 32'h38C5FFFF, 32'h00A6202A, 32'h00A62024,
                            32'h00A62025, 32'h00A62026, 32'h03E00008, 32'h10470003,
                            32'h0C000010, 32'h08000040, 32'hAC430004, 32'hFC000000,
                            32'h00A62021, 32'h24A5FFF0};

  initial begin
    int          t0, t1;
    logic [31:0] bne_pc;

    reset = 1'b1; if_valid = 1'b0; flush = 1'b0; id_ready = 1'b1;
    instruction = 32'h0; pc_in = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {21'h0, got_m}, 128'h0);
    check_eq("reset_valid", {127'h0, id_valid}, 128'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_if_ready", {127'h0, if_ready}, 128'h1);
    @(posedge clk); #1;

    // addi: registered one cycle after acceptance.
    send(I_ADDI, t0);
    check_eq("latency_valid", {127'h0, id_valid}, 128'h1);

    // Back-to-back mix of every decode class.
    for (int i = 0; i < 14; i++) send(mix[i], t0);

    // Load-use: two bubbles, dependent add accepted 3 cycles after lw.
    send(I_LW8, t0);
    push_bubbles(2);
    send(I_ADD8, t1);
    check_eq("loaduse_gap", 128'(t1 - t0), 128'd3);

    // lw to $0 never stalls.
    send(I_LW0, t0);
    send(I_ADD0, t1);
    check_eq("lw_r0_gap", 128'(t1 - t0), 128'd1);

    // Downstream back-pressure holding bne.
    bne_pc = pc_next;
    send(I_BNE, t0);
    id_ready    = 1'b0;
    instruction = I_ADDI;
    pc_in       = pc_next;
    if_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_ctrl", {121'h0, Branch, InvZero, ALUcntrl, id_valid, if_ready},
               {121'h0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0});
      check_eq("hold_pc", {96'h0, pc_out}, {96'h0, bne_pc});
      @(posedge clk); #1;
    end
    id_ready = 1'b1;
    send(I_ADDI, t0);

    // Flush during a stall bubble.
    send(I_LW8, t0);
    push_bubbles(1);
    instruction = I_ADD8;
    pc_in       = pc_next;
    if_valid    = 1'b1;
    @(negedge clk);
    check_eq("hazard_if_ready", {127'h0, if_ready}, 128'h0);
    @(posedge clk); #1;
    flush       = 1'b1;
    instruction = I_FLUSH;
    @(negedge clk);
    check_eq("flush_if_ready", {127'h0, if_ready}, 128'h1);
    @(posedge clk); #1;
    flush    = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", {127'h0, id_valid}, 128'h0);
    check_eq("flush_run_ready", {127'h0, if_ready}, 128'h1);
    repeat (3) @(posedge clk);
    #1;
    send(I_ADDI, t0);

    repeat (4) @(posedge clk);
    check_eq("queue_empty", 128'(sbq.size()), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
